// File: rtl/axi_lite_reg_sequencer.sv
// AXI4-Lite master that replays a packed table of register writes into a peripheral after a start pulse.
// Define AXI_REG_SEQ_READBACK_EN to read back and verify every write before moving to the next entry.
module axi_lite_reg_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                TIMEOUT   = 1024,
    localparam int               CNT_W     = $clog2(NUM_REGS + 1),
    localparam int               IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int               TMO_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       start,
    input  logic [CNT_W-1:0]           cfg_count,
    input  logic [NUM_REGS*16-1:0]     cfg_offset,
    input  logic [NUM_REGS*DATA_W-1:0] cfg_data,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [IDX_W-1:0]           err_idx,
    output logic [ADDR_W-1:0]          M_AXI_AWADDR,
    output logic [2:0]                 M_AXI_AWPROT,
    output logic                       M_AXI_AWVALID,
    input  logic                       M_AXI_AWREADY,
    output logic [DATA_W-1:0]          M_AXI_WDATA,
    output logic [DATA_W/8-1:0]        M_AXI_WSTRB,
    output logic                       M_AXI_WVALID,
    input  logic                       M_AXI_WREADY,
    input  logic [1:0]                 M_AXI_BRESP,
    input  logic                       M_AXI_BVALID,
    output logic                       M_AXI_BREADY,
    output logic [ADDR_W-1:0]          M_AXI_ARADDR,
    output logic [2:0]                 M_AXI_ARPROT,
    output logic                       M_AXI_ARVALID,
    input  logic                       M_AXI_ARREADY,
    input  logic [DATA_W-1:0]          M_AXI_RDATA,
    input  logic [1:0]                 M_AXI_RRESP,
    input  logic                       M_AXI_RVALID,
    output logic                       M_AXI_RREADY
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_WB   = 3'd2;
    localparam logic [2:0] ST_NEXT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;
`ifdef AXI_REG_SEQ_READBACK_EN
    localparam logic [2:0] ST_RA   = 3'd6;
    localparam logic [2:0] ST_RD   = 3'd7;
`endif

    logic [2:0]        state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [TMO_W-1:0]  tmo_reg;
    logic              loaded_reg;
    logic              aw_valid_reg;
    logic              w_valid_reg;
    logic              b_ready_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;
    logic [IDX_W-1:0]  err_idx_reg;
`ifdef AXI_REG_SEQ_READBACK_EN
    logic              ar_valid_reg;
    logic              r_ready_reg;
`endif

    logic [15:0]       offset_tab [NUM_REGS];
    logic [DATA_W-1:0] data_tab   [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
            assign offset_tab[gi] = cfg_offset[16*gi +: 16];
            assign data_tab[gi]   = cfg_data[DATA_W*gi +: DATA_W];
        end
    endgenerate

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_complete, tmo_hit, fail;

    assign aw_hs       = aw_valid_reg && M_AXI_AWREADY;
    assign w_hs        = w_valid_reg && M_AXI_WREADY;
    assign b_hs        = b_ready_reg && M_AXI_BVALID;
    assign wr_complete = loaded_reg && (!aw_valid_reg || aw_hs) && (!w_valid_reg || w_hs);
    assign tmo_hit     = (tmo_reg == TMO_W'(TIMEOUT - 1));
`ifdef AXI_REG_SEQ_READBACK_EN
    assign ar_hs = ar_valid_reg && M_AXI_ARREADY;
    assign r_hs  = r_ready_reg && M_AXI_RVALID;
`else
    assign ar_hs = 1'b0;
    assign r_hs  = 1'b0;
`endif

    // Any condition that aborts the sequence this cycle: error response, readback mismatch or stalled handshake.
    always_comb begin
        fail = 1'b0;
        case (state_reg)
            ST_WR:   fail = tmo_hit && !wr_complete;
            ST_WB:   fail = b_hs ? M_AXI_BRESP[1] : tmo_hit;
`ifdef AXI_REG_SEQ_READBACK_EN
            ST_RA:   fail = tmo_hit && !ar_hs;
            ST_RD:   fail = r_hs ? (M_AXI_RRESP[1] || (M_AXI_RDATA != data_reg)) : tmo_hit;
`endif
            default: fail = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            count_reg    <= '0;
            tmo_reg      <= '0;
            loaded_reg   <= 1'b0;
            aw_valid_reg <= 1'b0;
            w_valid_reg  <= 1'b0;
            b_ready_reg  <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            err_idx_reg  <= '0;
`ifdef AXI_REG_SEQ_READBACK_EN
            ar_valid_reg <= 1'b0;
            r_ready_reg  <= 1'b0;
`endif
        end else if (fail) begin
            state_reg    <= ST_ERR;
            aw_valid_reg <= 1'b0;
            w_valid_reg  <= 1'b0;
            b_ready_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            error_reg    <= 1'b1;
            err_idx_reg  <= idx_reg;
`ifdef AXI_REG_SEQ_READBACK_EN
            ar_valid_reg <= 1'b0;
            r_ready_reg  <= 1'b0;
`endif
        end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        error_reg <= 1'b0;
                        if (cfg_count != '0) begin
                            done_reg   <= 1'b0;
                            count_reg  <= cfg_count;
                            idx_reg    <= '0;
                            busy_reg   <= 1'b1;
                            tmo_reg    <= '0;
                            loaded_reg <= 1'b0;
                            state_reg  <= ST_WR;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    // First cycle captures the live table entry; VALIDs rise with a settled payload.
                    if (!loaded_reg) begin
                        addr_reg     <= BASE_ADDR + ADDR_W'(offset_tab[idx_reg]);
                        data_reg     <= data_tab[idx_reg];
                        aw_valid_reg <= 1'b1;
                        w_valid_reg  <= 1'b1;
                        loaded_reg   <= 1'b1;
                    end else begin
                        if (aw_hs) aw_valid_reg <= 1'b0;
                        if (w_hs) w_valid_reg <= 1'b0;
                        if (wr_complete) begin
                            b_ready_reg <= 1'b1;
                            tmo_reg     <= '0;
                            state_reg   <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    if (b_hs) begin
                        b_ready_reg <= 1'b0;
                        tmo_reg     <= '0;
`ifdef AXI_REG_SEQ_READBACK_EN
                        ar_valid_reg <= 1'b1;
                        state_reg    <= ST_RA;
`else
                        state_reg    <= ST_NEXT;
`endif
                    end
                end
`ifdef AXI_REG_SEQ_READBACK_EN
                ST_RA: begin
                    if (ar_hs) begin
                        ar_valid_reg <= 1'b0;
                        r_ready_reg  <= 1'b1;
                        tmo_reg      <= '0;
                        state_reg    <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (r_hs) begin
                        r_ready_reg <= 1'b0;
                        state_reg   <= ST_NEXT;
                    end
                end
`endif
                ST_NEXT: begin
                    if (CNT_W'(idx_reg) + CNT_W'(1) == count_reg) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg    <= idx_reg + IDX_W'(1);
                        loaded_reg <= 1'b0;
                        tmo_reg    <= '0;
                        state_reg  <= ST_WR;
                    end
                end
                // DONE and ERR are single-cycle exits; a start arriving here is dropped.
                ST_DONE: state_reg <= ST_IDLE;
                ST_ERR:  state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy          = busy_reg;
    assign done          = done_reg;
    assign error         = error_reg;
    assign err_idx       = err_idx_reg;
    assign M_AXI_AWADDR  = addr_reg;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = aw_valid_reg;
    assign M_AXI_WDATA   = data_reg;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = w_valid_reg;
    assign M_AXI_BREADY  = b_ready_reg;
    assign M_AXI_ARADDR  = addr_reg;
    assign M_AXI_ARPROT  = 3'b000;
`ifdef AXI_REG_SEQ_READBACK_EN
    assign M_AXI_ARVALID = ar_valid_reg;
    assign M_AXI_RREADY  = r_ready_reg;

    logic unused_inputs;
    assign unused_inputs = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};
`else
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{M_AXI_BRESP[0], M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
                             ar_hs, r_hs};
`endif

endmodule

// File: tb/tb_axi_lite_reg_sequencer.sv
// Self-checking bench for axi_lite_reg_sequencer: AXI4-Lite slave model with programmable stalls/faults,
// protocol monitor and a table-level reference model of the expected write stream and timing.
module tb_axi_lite_reg_sequencer;

    localparam int          NR   = 8;
    localparam int          DW   = 32;
    localparam int          TMO  = 1024;
    localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef AXI_REG_SEQ_READBACK_EN
    localparam int          PER  = 6;
`else
    localparam int          PER  = 4;
`endif

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        cfg_count = '0;
    logic [NR*16-1:0]  cfg_offset = '0;
    logic [NR*DW-1:0]  cfg_data = '0;
    logic              busy, done, error;
    logic [2:0]        err_idx;
    logic [31:0]       AWADDR, ARADDR, RDATA;
    logic [2:0]        AWPROT, ARPROT;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic [1:0]        BRESP, RRESP;

    axi_lite_reg_sequencer dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .cfg_count(cfg_count),
        .cfg_offset(cfg_offset), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Slave knobs (written only by the stimulus block)
    int  aw_lat = 0, w_lat = 0, err_entry = -1, wbase = 0;
    bit  b_never = 1'b0, corrupt = 1'b0;

    // Slave state (written only by the slave process)
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t         wlog[$];
    int          aw_cnt = 0, w_cnt = 0, b_count = 0;
    logic        aw_got = 1'b0, w_got = 1'b0, bvalid_s = 1'b0, rvalid_s = 1'b0;
    logic [31:0] got_addr = '0, got_data = '0, rdata_s = '0;
    logic [1:0]  bresp_s = '0;
    logic [31:0] sa, sd;
    logic        sha, shd;
`ifdef AXI_REG_SEQ_READBACK_EN
    logic [31:0] mem [logic [31:0]];
`endif

    assign AWREADY = AWVALID && (aw_cnt >= aw_lat);
    assign WREADY  = WVALID && (w_cnt >= w_lat);
    assign BVALID  = bvalid_s;
    assign BRESP   = bresp_s;
`ifdef AXI_REG_SEQ_READBACK_EN
    assign ARREADY = 1'b1;
    assign RVALID  = rvalid_s;
    assign RDATA   = rdata_s;
`else
    assign ARREADY = 1'b0;
    assign RVALID  = 1'b0;
    assign RDATA   = '0;
`endif
    assign RRESP   = 2'b00;

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            bvalid_s <= 1'b0; bresp_s <= 2'b00; rvalid_s <= 1'b0;
        end else begin
            aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
            if (bvalid_s && BREADY) begin
                bvalid_s <= 1'b0;
                b_count  <= b_count + 1;
            end
            sha = aw_got; sa = got_addr;
            if (AWVALID && AWREADY) begin sha = 1'b1; sa = AWADDR; end
            shd = w_got; sd = got_data;
            if (WVALID && WREADY) begin shd = 1'b1; sd = WDATA; end
            if (sha && shd) begin
                bresp_s  <= (wlog.size() - wbase == err_entry) ? 2'b10 : 2'b00;
                bvalid_s <= !b_never;
                wlog.push_back({sa, sd});
`ifdef AXI_REG_SEQ_READBACK_EN
                mem[sa] = sd;
`endif
                aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                aw_got <= sha; w_got <= shd; got_addr <= sa; got_data <= sd;
            end
`ifdef AXI_REG_SEQ_READBACK_EN
            if (rvalid_s && RREADY) rvalid_s <= 1'b0;
            if (ARVALID) begin
                rvalid_s <= 1'b1;
                rdata_s  <= (corrupt && ARADDR == BASE + 32'h18) ? 32'd1919 : mem[ARADDR];
            end
`endif
        end
    end

    // Protocol monitor: VALID held with stable payload until handshake, fixed PROT/STRB, activity count
    int          viol = 0, act = 0;
    logic        hold_aw = 1'b0, hold_w = 1'b0;
    logic [31:0] held_addr = '0, held_data = '0;
    always @(posedge ACLK) begin
        if (ARESET) begin
            hold_aw <= 1'b0; hold_w <= 1'b0;
        end else begin
            if ((hold_aw && (!AWVALID || AWADDR != held_addr)) || (hold_w && (!WVALID || WDATA != held_data))
                || (AWVALID && AWPROT != 3'b000) || (WVALID && WSTRB != 4'hF))
                viol <= viol + 1;
            hold_aw <= AWVALID && !AWREADY; held_addr <= AWADDR;
            hold_w  <= WVALID && !WREADY;   held_data <= WDATA;
            if (AWVALID || WVALID || ARVALID) act <= act + 1;
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference table
    logic [15:0] off_m [NR];
    logic [31:0] dat_m [NR];
    int          bbase;

    task automatic load_table();
        for (int i = 0; i < NR; i++) begin
            cfg_offset[16*i +: 16] = off_m[i];
            cfg_data[32*i +: 32]   = dat_m[i];
        end
    endtask

    task automatic load_tpg();
        off_m[0] = 16'h10; dat_m[0] = 32'd1080;
        off_m[1] = 16'h18; dat_m[1] = 32'd1920;
        off_m[2] = 16'h20; dat_m[2] = 32'd9;
        off_m[3] = 16'h40; dat_m[3] = 32'd2;
        off_m[4] = 16'h00; dat_m[4] = 32'h81;
        for (int i = 5; i < NR; i++) begin off_m[i] = 16'hFFFC; dat_m[i] = 32'hDEAD_0000 + i; end
        load_table();
    endtask

    task automatic run_seq(input int n, input int budget, output int cyc);
        wbase = wlog.size();
        bbase = b_count;
        cfg_count = 4'(n);
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        cyc = 0;
        while (!(done || error) && cyc < budget) begin
            @(negedge ACLK);
            cyc++;
        end
        $display("seq n=%0d aw_lat=%0d w_lat=%0d cycles=%0d done=%0b error=%0b err_idx=%0d",
                 n, aw_lat, w_lat, cyc, done, error, err_idx);
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, "_nwrites"}, 64'(wlog.size() - wbase), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (wbase + i < wlog.size()) begin
                check({tag, "_addr"}, 64'(wlog[wbase+i].addr), 64'(BASE + 32'(off_m[i])));
                check({tag, "_data"}, 64'(wlog[wbase+i].data), 64'(dat_m[i]));
            end
        end
    endtask

    initial begin
        int cyc, n, mx, a0;

        repeat (3) @(negedge ACLK);
        check("rst_awvalid", 64'(AWVALID), 64'd0);
        check("rst_wvalid", 64'(WVALID), 64'd0);
        check("rst_bready", 64'(BREADY), 64'd0);
        check("rst_arvalid", 64'(ARVALID), 64'd0);
        check("rst_flags", 64'({busy, done, error}), 64'd0);
        check("rst_err_idx", 64'(err_idx), 64'd0);
        ARESET = 1'b0;

        // 1: TPG bring-up, zero-wait slave
        load_tpg();
        run_seq(5, 200, cyc);
        check("t1_cycles", 64'(cyc), 64'(5 * PER));
        check("t1_flags", 64'({busy, done, error}), 64'b010);
        check_writes("t1", 5);
        check("t1_bcount", 64'(b_count - bbase), 64'd5);

        // 2: staggered AW/W handshakes, both orders
        aw_lat = 0; w_lat = 3;
        run_seq(5, 200, cyc);
        check("t2a_cycles", 64'(cyc), 64'(5 * (PER + 3)));
        check_writes("t2a", 5);
        check("t2a_bcount", 64'(b_count - bbase), 64'd5);
        aw_lat = 3; w_lat = 0;
        run_seq(5, 200, cyc);
        check("t2b_cycles", 64'(cyc), 64'(5 * (PER + 3)));
        check_writes("t2b", 5);
        check("t2b_bcount", 64'(b_count - bbase), 64'd5);
        aw_lat = 0;

        // 3: SLVERR on entry 2
        err_entry = 2;
        run_seq(5, 200, cyc);
        check("t3_flags", 64'({busy, done, error}), 64'b001);
        check("t3_err_idx", 64'(err_idx), 64'd2);
        check_writes("t3", 3);
        err_entry = -1;
        repeat (10) @(negedge ACLK);
        check("t3_no_more_writes", 64'(wlog.size() - wbase), 64'd3);

        // 4: BVALID never comes -> timeout measured from WB entry
        b_never = 1'b1;
        run_seq(5, 3000, cyc);
        check("t4_cycles", 64'(cyc), 64'(2 + TMO));
        check("t4_flags", 64'({busy, done, error}), 64'b001);
        check("t4_err_idx", 64'(err_idx), 64'd0);
        b_never = 1'b0;
        ARESET = 1'b1; @(negedge ACLK); ARESET = 1'b0;
        run_seq(5, 200, cyc);
        check("t4_recover_cycles", 64'(cyc), 64'(5 * PER));
        check("t4_recover_flags", 64'({busy, done, error}), 64'b010);
        check_writes("t4r", 5);

        // 5: reset in the middle of entry 1's write
        aw_lat = 2; w_lat = 2;
        wbase = wlog.size();
        cfg_count = 4'd5;
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        cyc = 0;
        while (!(wlog.size() - wbase == 1 && AWVALID) && cyc < 200) begin
            @(negedge ACLK);
            cyc++;
        end
        check("t5_reached_wr1", 64'(wlog.size() - wbase == 1 && AWVALID), 64'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("t5_valids", 64'({AWVALID, WVALID, BREADY, ARVALID}), 64'd0);
        check("t5_flags", 64'({busy, done, error}), 64'd0);
        ARESET = 1'b0;
        aw_lat = 0; w_lat = 0;
        a0 = act;
        run_seq(0, 20, cyc);
        check("t5_zero_cycles", 64'(cyc), 64'd0);
        check("t5_zero_done", 64'({busy, done, error}), 64'b010);
        repeat (5) @(negedge ACLK);
        check("t5_no_traffic", 64'(act - a0), 64'd0);

`ifdef AXI_REG_SEQ_READBACK_EN
        // 6: readback mismatch on 0x18, then clean readback run
        corrupt = 1'b1;
        run_seq(5, 200, cyc);
        check("t6_flags", 64'({busy, done, error}), 64'b001);
        check("t6_err_idx", 64'(err_idx), 64'd1);
        corrupt = 1'b0;
        run_seq(5, 200, cyc);
        check("t6_cycles", 64'(cyc), 64'd30);
        check("t6_done", 64'({busy, done, error}), 64'b010);
`endif

        // Randomized tables and stall patterns
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, NR);
            aw_lat = $urandom_range(0, 3);
            w_lat = $urandom_range(0, 3);
            mx = (aw_lat > w_lat) ? aw_lat : w_lat;
            for (int i = 0; i < NR; i++) begin
                off_m[i] = 16'($urandom) & 16'hFFFC;
                dat_m[i] = $urandom;
            end
            load_table();
            run_seq(n, 400, cyc);
            check("rnd_cycles", 64'(cyc), 64'(n * (PER + mx)));
            check("rnd_flags", 64'({busy, done, error}), 64'b010);
            check_writes("rnd", n);
            check("rnd_bcount", 64'(b_count - bbase), 64'(n));
        end

        check("protocol_violations", 64'(viol), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
